toggle_line_decoder: RTL and testbench

- Receive end of a toggle-encoded (T-style) serial line: a line transition means data 1, no transition means data 0.
- Recovers the bit stream, assembles it LSB-first into WIDTH-bit words, and presents each word on a valid/ready output port.
- A gate input (`enable`) qualifies sampling, matching the gated-latch conventions used in the sequential labs.
- Sits between a toggle-encoded source and any word-oriented consumer.

---
 rtl/seq_lab_pkg.sv | 11 +
 rtl/toggle_bit_recover.sv | 22 ++
 rtl/toggle_line_decoder.sv | 112 +++++++++++
 tb/tb_toggle_line_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_lab_pkg.sv
// Shared types and defaults for the sequential-lab blocks.
package seq_lab_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/toggle_bit_recover.sv
// Toggle-line bit recovery: a transition since the previous edge is a 1.
module toggle_bit_recover (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic line_i,
  output logic bit_o,
  output logic bit_en_o
);

  logic line_prev_q;

  // Tracked on every edge, gated or not, so re-enabling never sees a stale level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_prev_q <= '0;
    else        line_prev_q <= line_i;
  end

  assign bit_o    = line_i ^ line_prev_q;
  assign bit_en_o = enable_i;

endmodule

// File: rtl/toggle_line_decoder.sv
// Toggle-line receiver: recovers bits, packs them LSB-first into words, valid/ready output.
module toggle_line_decoder
  import seq_lab_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             line_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  input  logic             ovf_clr
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d, cnt_base;
  logic [WIDTH-1:0]   shift_reg_q, shift_reg_d, word;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               overflow_q, overflow_d;
  logic               bit_val, bit_en, do_shift, complete, drop;

  toggle_bit_recover u_recover (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .line_i   (line_in),
    .bit_o    (bit_val),
    .bit_en_o (bit_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_reg_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_reg_q  <= shift_reg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    do_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bit_en) begin
          state_d  = SHIFT;
          do_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_en) do_shift = 1'b1;
        else        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // frame_start realigns before this edge's sample is merged.
    cnt_base = frame_start ? '0 : bit_cnt_q;
    word     = frame_start ? '0 : shift_reg_q;
    if (do_shift) word[cnt_base] = bit_val;

    complete = do_shift && (cnt_base == CNT_W'(WIDTH - 1));

    if (complete) begin
      bit_cnt_d   = '0;
      shift_reg_d = '0;
    end else if (do_shift) begin
      bit_cnt_d   = cnt_base + 1'b1;
      shift_reg_d = word;
    end else begin
      bit_cnt_d   = cnt_base;
      shift_reg_d = word;
    end

    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    drop         = 1'b0;
    if (complete) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = word;
        data_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    // A drop on the clearing edge keeps the flag set.
    overflow_d = drop | (overflow_q & ~ovf_clr);
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_toggle_line_decoder.sv
// Directed bench for toggle_line_decoder with a word-level reference model.
module tb_toggle_line_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         line_in = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         overflow;
  logic         ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  toggle_line_decoder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .line_in     (line_in),
    .frame_start (frame_start),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: bits collected as a position and an accumulated value.
  logic         m_prev;
  int unsigned  m_pos;
  int unsigned  m_acc;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    int unsigned b;
    bit          done, dropped;
    logic [W-1:0] w;
    if (!rst_n) begin
      m_prev = 0; m_pos = 0; m_acc = 0; m_data = '0; m_valid = 0; m_ovf = 0;
    end else begin
      b = (line_in != m_prev) ? 1 : 0;
      m_prev = line_in;
      if (frame_start) begin m_pos = 0; m_acc = 0; end
      done = 0; dropped = 0; w = '0;
      if (enable) begin
        m_acc = m_acc + b * (1 << m_pos);
        m_pos = m_pos + 1;
        if (m_pos == W) begin
          done = 1; w = m_acc[W-1:0]; m_pos = 0; m_acc = 0;
        end
      end
      if (done) begin
        if (!m_valid || data_ready) begin m_data = w; m_valid = 1; end
        else begin dropped = 1; m_ovf = 1; end
      end else if (m_valid && data_ready) begin
        m_valid = 0;
      end
      if (ovf_clr && !dropped) m_ovf = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("model.data_out",   32'(data_out),   32'(m_data));
      check("model.data_valid", 32'(data_valid), 32'(m_valid));
      check("model.overflow",   32'(overflow),   32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    enable  = 1'b1;
    line_in = line_in ^ b;
    tick();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i <= hi; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int unsigned n);
    enable = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq;
    #12;
    check("reset.data_out",   32'(data_out),   0);
    check("reset.data_valid", 32'(data_valid), 0);
    check("reset.overflow",   32'(overflow),   0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic word from an explicit line sequence.
    data_ready = 1'b1;
    seq = 8'b0110_0011;
    for (int i = 0; i < 8; i++) begin
      enable  = 1'b1;
      line_in = seq[i];
      tick();
    end
    check("basic.data_out",   32'(data_out),   32'h A5);
    check("basic.data_valid", 32'(data_valid), 1);
    check("basic.overflow",   32'(overflow),   0);
    idle(1);
    check("basic.valid_one_cycle", 32'(data_valid), 0);

    // Backpressure and overflow.
    data_ready = 1'b0;
    send_bits(8'h A5, 0, 7);
    send_bits(8'h 00, 0, 7);
    check("bp.data_out",   32'(data_out),   32'h A5);
    check("bp.data_valid", 32'(data_valid), 1);
    check("bp.overflow",   32'(overflow),   1);
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;
    check("bp.drained",      32'(data_valid), 0);
    check("bp.ovf_sticky",   32'(overflow),   1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("bp.ovf_cleared",  32'(overflow),   0);

    // Gating mid-word with the line toggling while disabled.
    data_ready = 1'b1;
    send_bits(8'h 3C, 0, 3);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      line_in = ~line_in;
      tick();
    end
    send_bits(8'h 3C, 4, 7);
    check("gate.data_out",   32'(data_out),   32'h 3C);
    check("gate.data_valid", 32'(data_valid), 1);

    // Junk then realign with frame_start on the first bit.
    send_bits(8'b0000_1101, 0, 4);
    frame_start = 1'b1;
    send_bit(1'b1);
    frame_start = 1'b0;
    send_bits(8'h 81, 1, 7);
    check("frame.data_out",   32'(data_out),   32'h 81);
    check("frame.data_valid", 32'(data_valid), 1);
    check("frame.overflow",   32'(overflow),   0);

    // Consume on the same edge a new word completes.
    idle(1);
    data_ready = 1'b0;
    send_bits(8'h 11, 0, 7);
    check("simul.first", 32'(data_out), 32'h 11);
    send_bits(8'h 22, 0, 6);
    data_ready = 1'b1;
    send_bit(1'b0);
    data_ready = 1'b0;
    check("simul.data_out",   32'(data_out),   32'h 22);
    check("simul.data_valid", 32'(data_valid), 1);
    check("simul.overflow",   32'(overflow),   0);

    // Drop and clear on the same edge: the drop wins.
    send_bits(8'h 77, 0, 6);
    ovf_clr = 1'b1;
    send_bit(1'b0);
    ovf_clr = 1'b0;
    check("setwins.overflow", 32'(overflow), 1);
    check("setwins.data_out", 32'(data_out), 32'h 22);

    // Asynchronous reset in the middle of a word.
    send_bits(8'h 5A, 0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.data_out",   32'(data_out),   0);
    check("areset.data_valid", 32'(data_valid), 0);
    check("areset.overflow",   32'(overflow),   0);
    enable  = 1'b0;
    line_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_ready = 1'b1;
    send_bits(8'h 5A, 0, 7);
    check("areset.word",  32'(data_out),   32'h 5A);
    check("areset.valid", 32'(data_valid), 1);

    // Back-to-back words with no bubbles.
    send_bits(8'h C3, 0, 7);
    check("b2b.first", 32'(data_out), 32'h C3);
    send_bits(8'h 96, 0, 7);
    check("b2b.second", 32'(data_out), 32'h 96);
    check("b2b.valid",  32'(data_valid), 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
